// File: rtl/mc_defs.sv
// mc_defs: shared encodings for the multi-cycle controller (states, classes, opcodes, ALU/nPC selects).
package mc_defs;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXE_R, S_EXE_I, S_MEM_ADR, S_MEM_RD,
    S_MEM_WR, S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP
  } state_t;
  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_ILL
  } cls_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_LUI = 2'd3;
  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BEQ = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  function automatic logic [1:0] alu_of(cls_t c);
    return c == C_SUBU ? ALU_SUB : c == C_ORI ? ALU_OR : c == C_LUI ? ALU_LUI : ALU_ADD;
  endfunction
endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: instruction fields in, control strobes and debug status out of the controller.
interface mc_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0] opcode;
  logic [5:0] funct;
  logic zero;
  logic pc_we;
  logic [1:0] nPC_sel;
  logic ir_we;
  logic reg_we;
  logic reg_dst;
  logic alu_src;
  logic [1:0] alu_op;
  logic ext_op;
  logic mem_we;
  logic mem_to_reg;
  logic illegal;
  logic [3:0] state;
  logic [CNT_W-1:0] instr_cnt;
  modport master (
    input opcode, funct, zero,
    output pc_we, nPC_sel, ir_we, reg_we, reg_dst, alu_src, alu_op, ext_op,
    mem_we, mem_to_reg, illegal, state, instr_cnt
  );
  modport slave (
    output opcode, funct, zero,
    input pc_we, nPC_sel, ir_we, reg_we, reg_dst, alu_src, alu_op, ext_op,
    mem_we, mem_to_reg, illegal, state, instr_cnt
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/funct to instruction class.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls
);
  always_comb begin
    cls = opcode == OP_RTYPE ? (funct == FN_ADDU ? C_ADDU : funct == FN_SUBU ? C_SUBU : C_ILL) :
          opcode == OP_ORI ? C_ORI :
          opcode == OP_LUI ? C_LUI :
          opcode == OP_LW  ? C_LW  :
          opcode == OP_SW  ? C_SW  :
          opcode == OP_BEQ ? C_BEQ :
          opcode == OP_J   ? C_J   : C_ILL;
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller; sequences fetch/decode/execute and retires one instruction per PC update.
module mc_ctrl
  import mc_defs::*;
#(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  mc_ctrl_if.master bus
);
  state_t st, nxt;
  cls_t cls, dec;
  logic ill;
  logic pc_we;
  logic [CNT_W-1:0] cnt;
  mc_decode u_dec (.opcode(bus.opcode), .funct(bus.funct), .cls(dec));
  always_comb begin
    case (st)
      S_FETCH:   nxt = S_DECODE;
      S_DECODE:  nxt = (dec == C_ADDU || dec == C_SUBU) ? S_EXE_R :
                       (dec == C_ORI || dec == C_LUI) ? S_EXE_I :
                       (dec == C_LW || dec == C_SW) ? S_MEM_ADR :
                       dec == C_BEQ ? S_BRANCH : dec == C_J ? S_JUMP : S_FETCH;
      S_EXE_R:   nxt = S_WB_ALU;
      S_EXE_I:   nxt = S_WB_ALU;
      S_MEM_ADR: nxt = cls == C_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  nxt = S_WB_MEM;
      default:   nxt = S_FETCH;
    endcase
  end
  // An illegal instruction retires straight out of DECODE, so pc_we there looks at the live decode.
  assign pc_we = (st == S_DECODE && dec == C_ILL) ||
                 st inside {S_MEM_WR, S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP};
  assign bus.pc_we      = pc_we;
  assign bus.nPC_sel    = st == S_BRANCH ? NPC_BEQ : st == S_JUMP ? NPC_J : NPC_SEQ;
  assign bus.ir_we      = st == S_FETCH;
  assign bus.reg_we     = st inside {S_WB_MEM, S_WB_ALU};
  assign bus.reg_dst    = st == S_WB_ALU && (cls == C_ADDU || cls == C_SUBU);
  assign bus.alu_src    = st inside {S_EXE_I, S_MEM_ADR, S_MEM_RD, S_MEM_WR} ||
                          (st == S_WB_ALU && (cls == C_ORI || cls == C_LUI));
  assign bus.alu_op     = st inside {S_EXE_R, S_EXE_I, S_WB_ALU} ? alu_of(cls) :
                          st == S_BRANCH ? ALU_SUB : ALU_ADD;
  assign bus.ext_op     = st inside {S_MEM_ADR, S_MEM_RD, S_MEM_WR, S_BRANCH};
  assign bus.mem_we     = st == S_MEM_WR;
  assign bus.mem_to_reg = st == S_WB_MEM;
  assign bus.illegal    = ill;
  assign bus.state      = st;
  assign bus.instr_cnt  = cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= S_FETCH;
      cls <= C_NOP;
      ill <= 1'b0;
      cnt <= '0;
    end else begin
      st <= nxt;
      if (st == S_DECODE) cls <= dec;
      if (st == S_DECODE && dec == C_ILL) ill <= 1'b1;
      if (pc_we) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and random instruction streams checked against a per-class cycle table.
module tb_mc_ctrl;
  import mc_defs::*;
  localparam int W = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mc_ctrl_if #(.CNT_W(W)) bus ();
  mc_ctrl #(.CNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef enum {T_ADDU, T_SUBU, T_ORI, T_LUI, T_LW, T_SW, T_BEQ, T_J, T_ILL} tcls_t;
  typedef struct packed {
    logic pc_we; logic [1:0] npc; logic ir_we; logic reg_we; logic reg_dst;
    logic alu_src; logic [1:0] alu_op; logic ext_op; logic mem_we; logic mem_to_reg;
  } outs_t;
  int checks = 0;
  int errors = 0;
  int m_cnt = 0;
  logic m_ill = 1'b0;

  function automatic tcls_t classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'h00: return fn == 6'h21 ? T_ADDU : fn == 6'h23 ? T_SUBU : T_ILL;
      6'h0d: return T_ORI;
      6'h0f: return T_LUI;
      6'h23: return T_LW;
      6'h2b: return T_SW;
      6'h04: return T_BEQ;
      6'h02: return T_J;
      default: return T_ILL;
    endcase
  endfunction

  function automatic int n_cyc(tcls_t c);
    case (c)
      T_LW: return 5;
      T_BEQ, T_J: return 3;
      T_ILL: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic outs_t expect_at(tcls_t c, int k);
    outs_t e = '0;
    logic last = (k == n_cyc(c) - 1);
    e.ir_we = (k == 0);
    e.pc_we = last;
    if (k >= 2) begin
      case (c)
        T_ADDU, T_SUBU: begin
          e.alu_op = c == T_SUBU ? 2'd1 : 2'd0;
          e.reg_we = last;
          e.reg_dst = last;
        end
        T_ORI, T_LUI: begin
          e.alu_src = 1'b1;
          e.alu_op = c == T_ORI ? 2'd2 : 2'd3;
          e.reg_we = last;
        end
        T_LW: begin
          e.alu_src = !last;
          e.ext_op = !last;
          e.reg_we = last;
          e.mem_to_reg = last;
        end
        T_SW: begin
          e.alu_src = 1'b1;
          e.ext_op = 1'b1;
          e.mem_we = last;
        end
        T_BEQ: begin
          e.alu_op = 2'd1;
          e.ext_op = 1'b1;
          e.npc = 2'b01;
        end
        T_J: e.npc = 2'b10;
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic outs_t observed();
    return {bus.pc_we, bus.nPC_sel, bus.ir_we, bus.reg_we, bus.reg_dst, bus.alu_src,
            bus.alu_op, bus.ext_op, bus.mem_we, bus.mem_to_reg};
  endfunction

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input outs_t got, input outs_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    tcls_t c = classify(op, fn);
    bus.opcode = op;
    bus.funct = fn;
    bus.zero = 1'($urandom_range(0, 1));
    for (int k = 0; k < n_cyc(c); k++) begin
      if (k == 0) chk_val($sformatf("%s fetch state", c.name()), 32'(bus.state), 32'(S_FETCH));
      chk_outs($sformatf("%s cycle%0d", c.name(), k), observed(), expect_at(c, k));
      @(posedge clk);
      #1;
    end
    m_cnt = (m_cnt + 1) % (1 << W);
    if (c == T_ILL) m_ill = 1'b1;
    chk_val($sformatf("%s instr_cnt", c.name()), 32'(bus.instr_cnt), 32'(m_cnt));
    chk_val($sformatf("%s illegal", c.name()), 32'(bus.illegal), 32'(m_ill));
  endtask

  initial begin
    logic [5:0] ops [10];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h3f, 6'h00};
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_val("reset state", 32'(bus.state), 32'(S_FETCH));
    chk_val("reset cnt", 32'(bus.instr_cnt), 0);
    chk_val("reset illegal", 32'(bus.illegal), 0);
    run_instr(6'h00, 6'h21);
    run_instr(6'h23, 6'h00);
    run_instr(6'h2b, 6'h00);
    run_instr(6'h04, 6'h00);
    run_instr(6'h02, 6'h00);
    run_instr(6'h00, 6'h23);
    run_instr(6'h3f, 6'h00);
    run_instr(6'h0d, 6'h00);
    run_instr(6'h0f, 6'h00);
    bus.opcode = 6'h23;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_cnt = 0;
    m_ill = 1'b0;
    chk_val("midlw state", 32'(bus.state), 32'(S_FETCH));
    chk_val("midlw strobes", {29'd0, bus.pc_we, bus.reg_we, bus.mem_we}, 0);
    chk_val("midlw cnt", 32'(bus.instr_cnt), 0);
    chk_val("midlw illegal", 32'(bus.illegal), 0);
    for (int i = 0; i < 16; i++) run_instr(6'h02, 6'h00);
    chk_val("wrap cnt", 32'(bus.instr_cnt), 0);
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 9)];
      fn = 6'($urandom_range(0, 2) == 0 ? 6'h21 : $urandom_range(0, 1) == 0 ? 6'h23 : $urandom);
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      run_instr(op, fn);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
